vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FB_W, 160, framebuffer width in pixels.
REQ-002 Parameter FB_H, 120, framebuffer height in pixels.
REQ-003 Parameter SCALE_SHIFT, 2, log2 of screen-to-framebuffer scale factor.
REQ-004 Parameter ADDR_W, 15, VRAM address width.
REQ-005 Parameter DATA_W, 8, pixel width.
REQ-006 The block SHALL have a single clock, clk; reset is asynchronous and active-high.
REQ-007 clk  input  1  system clock (pixel rate = clk/2).
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 p_tick  input  1  pixel strobe from the sync generator.
REQ-010 video_on  input  1  visible-area flag.
REQ-011 pixel_x  input  10  current screen column.
REQ-012 pixel_y  input  10  current screen row.
REQ-013 wr_req  input  1  writer request; held with address and data until wr_ack.
REQ-014 wr_addr  input  ADDR_W  writer address.
REQ-015 wr_data  input  DATA_W  writer data.
REQ-016 wr_ack  output  1  one-cycle write-accept pulse.
REQ-017 mem_addr  output  ADDR_W  registered VRAM address.
REQ-018 mem_we  output  1  registered VRAM write enable.
REQ-019 mem_wdata  output  DATA_W  registered VRAM write data.
REQ-020 mem_rdata  input  DATA_W  VRAM read data, one-cycle synchronous latency.
REQ-021 pix_data  output  DATA_W  fetched pixel.
REQ-022 pix_valid  output  1  pix_data valid for one cycle.
REQ-023 stall_cnt  output  16  saturating count of cycles wr_req waited.

Function
REQ-024 FSM states IDLE, FETCH, WRITE; state reflects the access driven on mem_* in the current cycle.
REQ-025 At an edge with p_tick=1 and video_on=1, next state is FETCH: mem_addr = (pixel_y>>SCALE_SHIFT)*FB_W + (pixel_x>>SCALE_SHIFT), truncated to ADDR_W; mem_we=0.
REQ-026 At an edge with no fetch condition and wr_req=1, next state is WRITE: mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1, wr_ack=1 for exactly that cycle.
REQ-027 Otherwise next state is IDLE with mem_we=0; mem_addr and mem_wdata hold their values.
REQ-028 Display fetch has strict priority over the writer on simultaneous requests.
REQ-029 wr_req still high in the cycle after wr_ack SHALL be treated as a new request; no cycle needs to separate back-to-back writes.
REQ-030 A write with wr_addr >= FB_W*FB_H SHALL be acked with mem_we held 0.
REQ-031 pix_data SHALL register mem_rdata, and pix_valid SHALL pulse, exactly 2 cycles after the edge that sampled the fetch condition.
REQ-032 stall_cnt SHALL increment on each edge with wr_req=1 and no grant, saturating at 0xFFFF.

Reset
REQ-033 Reset SHALL force: state IDLE; mem_addr, mem_wdata, and pix_data to 0; mem_we, wr_ack, and pix_valid to 0; stall_cnt to 0.
REQ-034 Reset mid-operation SHALL drop any in-flight fetch or write: no wr_ack and no pix_valid for it after reset release.

Configuration
REQ-035 With VRAM_ARBITER_BLANK_WR_EN defined, a write SHALL be granted only at edges with video_on=0; requests during video_on=1 stall and count in stall_cnt.
REQ-036 Without VRAM_ARBITER_BLANK_WR_EN, writes SHALL be granted per REQ-026 in any non-fetch cycle.

Structure
REQ-037 Package vram_pkg SHALL hold the FSM state typedef and the FB_W/FB_H/SCALE_SHIFT/ADDR_W/DATA_W defaults.
REQ-038 Sub-module vram_addr_gen SHALL compute the fetch address combinationally from pixel_x and pixel_y.

Verification
REQ-039 Drive a 50 MHz clk with p_tick every 2nd cycle, video_on=1, pixel_x=8, pixel_y=4 -> mem_addr=162 in FETCH; pix_valid 2 cycles after the sampling edge carries mem_rdata.
REQ-040 Assert wr_req at an edge where p_tick=1 and video_on=1 -> FETCH first; wr_ack one cycle later; stall_cnt=1.
REQ-041 Blanking (video_on=0), wr_req held for 4 cycles with addresses 0..3 -> four consecutive wr_ack pulses, mem_we=1 each cycle.
REQ-042 Write wr_addr=19200 -> wr_ack=1 and mem_we=0.
REQ-043 Assert reset in the WRITE cycle -> all outputs 0 immediately; no wr_ack or pix_valid after release.
REQ-044 With VRAM_ARBITER_BLANK_WR_EN, wr_req held during 10 visible cycles -> no ack and stall_cnt=10; ack on the first edge with video_on=0.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: arbiter state type and default framebuffer geometry.
package vram_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
    localparam int DEF_FB_W        = 160;
    localparam int DEF_FB_H        = 120;
    localparam int DEF_SCALE_SHIFT = 2;
    localparam int DEF_ADDR_W      = 15;
    localparam int DEF_DATA_W      = 8;
endpackage

// File: rtl/vram_addr_gen.sv
// vram_addr_gen: maps a screen pixel to its downscaled framebuffer address.
module vram_addr_gen import vram_pkg::*; #(
    parameter int FB_W        = DEF_FB_W,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] addr
);
    assign addr = ADDR_W'(pixel_y >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(pixel_x >> SCALE_SHIFT);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between display fetches and a writer.
// Define VRAM_ARBITER_BLANK_WR_EN to restrict writes to blanking (video_on=0).
module vram_arbiter import vram_pkg::*; #(
    parameter int FB_W        = DEF_FB_W,
    parameter int FB_H        = DEF_FB_H,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [15:0]       stall_cnt
);
    localparam int unsigned FB_SIZE = FB_W * FB_H;

    state_t            state;
    logic              rd_pend;
    logic              fetch;
    logic              grant;
    logic [ADDR_W-1:0] fetch_addr;

    vram_addr_gen #(.FB_W(FB_W), .SCALE_SHIFT(SCALE_SHIFT), .ADDR_W(ADDR_W)) u_addr_gen (
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .addr(fetch_addr)
    );

    assign fetch = p_tick & video_on;
`ifdef VRAM_ARBITER_BLANK_WR_EN
    assign grant = wr_req & ~fetch & ~video_on;
`else
    assign grant = wr_req & ~fetch;
`endif

    // rd_pend marks the cycle after FETCH, when mem_rdata carries the fetched pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            wr_ack    <= 1'b0;
            rd_pend   <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= fetch ? FETCH : grant ? WRITE : IDLE;
            mem_we <= grant && (32'(wr_addr) < FB_SIZE);
            wr_ack <= grant;
            if (fetch)
                mem_addr <= fetch_addr;
            else if (grant) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
            rd_pend   <= state == FETCH;
            pix_valid <= rd_pend;
            if (rd_pend)
                pix_data <= mem_rdata;
            if (wr_req && !grant && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: transaction-level model of the arbiter plus directed vectors.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick, video_on, wr_req;
    logic [9:0]  pixel_x, pixel_y;
    logic [14:0] wr_addr, mem_addr;
    logic [7:0]  wr_data, mem_wdata, mem_rdata, pix_data;
    logic        wr_ack, mem_we, pix_valid;
    logic [15:0] stall_cnt;

    always #10 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_data(pix_data),
        .pix_valid(pix_valid), .stall_cnt(stall_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // synchronous VRAM with one-cycle read latency
    logic [7:0] ram [32768];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // model: fetch sampled at edge n reads at n+1, presents the pixel at n+2
    typedef struct { int due; int val; } ev_t;
    ev_t        rdq[$];
    ev_t        outq[$];
    logic [7:0] shadow [32768];
    int         m_addr, m_wdata, m_stall, cyc_n;
    logic       m_we, m_ack, m_pv;
    logic [7:0] m_pix;

    initial for (int i = 0; i < 32768; i++) begin
        ram[i]    = 8'(i * 7 + 3);
        shadow[i] = 8'(i * 7 + 3);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdq.delete();
            outq.delete();
            m_addr  <= 0;
            m_wdata <= 0;
            m_stall <= 0;
            m_we    <= 1'b0;
            m_ack   <= 1'b0;
            m_pv    <= 1'b0;
            m_pix   <= 8'd0;
            cyc_n   <= 0;
        end else begin
            automatic bit   f = p_tick && video_on;
`ifdef VRAM_ARBITER_BLANK_WR_EN
            automatic bit   g = wr_req && !f && !video_on;
`else
            automatic bit   g = wr_req && !f;
`endif
            automatic int   a = (int'(pixel_y) / 4 * 160 + int'(pixel_x) / 4) % 32768;
            automatic ev_t  e;
            cyc_n <= cyc_n + 1;
            m_pv  <= 1'b0;
            if (outq.size() > 0 && outq[0].due == cyc_n) begin
                m_pix <= 8'(outq[0].val);
                m_pv  <= 1'b1;
                void'(outq.pop_front());
            end
            if (rdq.size() > 0 && rdq[0].due == cyc_n) begin
                e.due = cyc_n + 1;
                e.val = int'(shadow[rdq[0].val]);
                outq.push_back(e);
                void'(rdq.pop_front());
            end
            if (f) begin
                m_addr <= a;
                m_we   <= 1'b0;
                m_ack  <= 1'b0;
                e.due  = cyc_n + 1;
                e.val  = a;
                rdq.push_back(e);
            end else if (g) begin
                m_addr  <= int'(wr_addr);
                m_wdata <= int'(wr_data);
                m_we    <= int'(wr_addr) < 19200;
                m_ack   <= 1'b1;
                if (int'(wr_addr) < 19200) shadow[wr_addr] <= wr_data;
            end else begin
                m_we  <= 1'b0;
                m_ack <= 1'b0;
            end
            if (wr_req && !g && m_stall < 65535) m_stall <= m_stall + 1;
        end
    end

    always @(negedge clk) begin
        chk("mem_addr", 32'(mem_addr), m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_wdata", 32'(mem_wdata), m_wdata);
        chk("wr_ack", 32'(wr_ack), 32'(m_ack));
        chk("pix_valid", 32'(pix_valid), 32'(m_pv));
        chk("pix_data", 32'(pix_data), 32'(m_pix));
        chk("stall_cnt", 32'(stall_cnt), m_stall);
    end

    task automatic cyc(input bit pt, input bit vo, input int px, input int py,
                       input bit wr, input int wa, input int wd);
        p_tick   = pt;
        video_on = vo;
        pixel_x  = 10'(px);
        pixel_y  = 10'(py);
        wr_req   = wr;
        wr_addr  = 15'(wa);
        wr_data  = 8'(wd);
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        p_tick = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_ack", 32'(wr_ack), 0);
        chk("rst_pv", 32'(pix_valid), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        reset = 1'b0;

        cyc(1, 1, 8, 4, 0, 0, 0);
        chk("fetch_addr162", 32'(mem_addr), 162);
        chk("fetch_we", 32'(mem_we), 0);
        cyc(0, 1, 8, 4, 0, 0, 0);
        chk("pv_early", 32'(pix_valid), 0);
        cyc(0, 1, 8, 4, 0, 0, 0);
        chk("pv_lat2", 32'(pix_valid), 1);
        chk("pix_162", 32'(pix_data), 113);
        for (int i = 0; i < 16; i++) cyc(i % 2 == 0, 1, i * 41, i * 29, 0, 0, 0);

`ifndef VRAM_ARBITER_BLANK_WR_EN
        cyc(1, 1, 0, 0, 1, 100, 'h5A);
        chk("prio_ack0", 32'(wr_ack), 0);
        chk("prio_stall1", 32'(stall_cnt), 1);
        cyc(0, 1, 0, 0, 1, 100, 'h5A);
        chk("prio_ack1", 32'(wr_ack), 1);
        chk("prio_we", 32'(mem_we), 1);
        chk("prio_addr", 32'(mem_addr), 100);
        chk("prio_wdata", 32'(mem_wdata), 'h5A);
`endif

        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, i, 'hA0 + i);
            chk("b2b_ack", 32'(wr_ack), 1);
            chk("b2b_we", 32'(mem_we), 1);
            chk("b2b_addr", 32'(mem_addr), 32'(i));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("idle_ack", 32'(wr_ack), 0);
        chk("idle_hold", 32'(mem_addr), 3);
        cyc(1, 1, 8, 0, 0, 0, 0);
        cyc(0, 1, 8, 0, 0, 0, 0);
        cyc(0, 1, 8, 0, 0, 0, 0);
        chk("readback_pv", 32'(pix_valid), 1);
        chk("readback_a2", 32'(pix_data), 'hA2);

        cyc(0, 0, 0, 0, 1, 19200, 'hFF);
        chk("oob_ack", 32'(wr_ack), 1);
        chk("oob_we", 32'(mem_we), 0);
        cyc(0, 0, 0, 0, 1, 19199, 'h3C);
        chk("last_we", 32'(mem_we), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 64; i++)
            cyc(i % 2 == 1, (i / 8) % 2 == 0, i * 13, i * 7, i % 3 != 0, (i * 301) % 20000, i);

        cyc(1, 1, 8, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 5, 'h11);
        chk("pre_rst_ack", 32'(wr_ack), 1);
        #5 reset = 1'b1;
        #1;
        chk("arst_we", 32'(mem_we), 0);
        chk("arst_ack", 32'(wr_ack), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_wdata", 32'(mem_wdata), 0);
        chk("arst_pix", 32'(pix_data), 0);
        chk("arst_stall", 32'(stall_cnt), 0);
        wr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("post_rst_ack", 32'(wr_ack), 0);
            chk("post_rst_pv", 32'(pix_valid), 0);
        end

`ifdef VRAM_ARBITER_BLANK_WR_EN
        for (int i = 0; i < 10; i++) begin
            cyc(i % 2 == 0, 1, 0, 0, 1, 7, 'h77);
            chk("blank_noack", 32'(wr_ack), 0);
        end
        chk("blank_stall10", 32'(stall_cnt), 10);
        cyc(0, 0, 0, 0, 1, 7, 'h77);
        chk("blank_ack", 32'(wr_ack), 1);
        chk("blank_stall_hold", 32'(stall_cnt), 10);
        cyc(0, 0, 0, 0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
